// File: rtl/digit_scan_driver.sv
// Four-digit seven-segment scan driver: prescaled one-hot digit ring plus
// registered active-low anode/decimal-point drives with leading-zero blanking.
module digit_scan_driver #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        blank_lz,
    input  logic [15:0] N,
    input  logic [3:0]  dp_in,
    output logic [3:0]  sel,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             tick_c;
    logic             sel_onehot_c;
    logic [3:0]       sel_next;
    logic [3:0]       blank_mask_c;
    logic [3:0]       lit_c;

    // Dwell prescaler; hold freezes the count and suppresses the tick.
    always_comb begin
        tick_c   = 1'b0;
        cnt_next = cnt;
        if (!hold) begin
            if (cnt == CNT_MAX) begin
                tick_c   = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Digit ring; any corrupted (non-one-hot) pattern is replaced by digit 0.
    always_comb begin
        sel_onehot_c = (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);
        sel_next     = sel;
        if (tick_c) begin
            sel_next = sel_onehot_c ? {sel[2:0], sel[3]} : 4'b0001;
        end
    end

    always_comb begin
        blank_mask_c[3] = blank_lz && (N[15:12] == 4'h0);
        blank_mask_c[2] = blank_lz && (N[15:8]  == 8'h00);
        blank_mask_c[1] = blank_lz && (N[15:4]  == 12'h000);
        blank_mask_c[0] = 1'b0;
        lit_c           = sel_next & ~blank_mask_c;
    end

    // an/dp follow sel_next so they line up with sel without an extra cycle of lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sel <= 4'b0001;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            cnt <= cnt_next;
            sel <= sel_next;
            an  <= ~lit_c;
            dp  <= ~|(lit_c & dp_in);
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed self-checking bench for digit_scan_driver (DIV=4 main instance, DIV=1 side instance).
module tb_digit_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        blank_lz;
    logic [15:0] N;
    logic [3:0]  dp_in;
    logic [3:0]  sel, an, sel1, an1;
    logic        dp, dp1;

    int total = 0;
    int bad   = 0;

    logic [3:0] ring [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    digit_scan_driver #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .hold(hold), .blank_lz(blank_lz),
        .N(N), .dp_in(dp_in), .sel(sel), .an(an), .dp(dp)
    );

    digit_scan_driver #(.DIV(1)) dut1 (
        .clk(clk), .reset(reset), .hold(hold), .blank_lz(blank_lz),
        .N(N), .dp_in(dp_in), .sel(sel1), .an(an1), .dp(dp1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; blank_lz = 1'b0; N = 16'h1234; dp_in = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (sel !== 4'b0001 || an !== 4'b1111 || dp !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d sel=%b an=%b dp=%b want sel=0001 an=1111 dp=1", c, sel, an, dp);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            logic [3:0] es;
            step();
            es = ring[(e / 4) % 4];
            total++;
            if (sel !== es || an !== ~es || dp !== 1'b1) begin
                bad++;
                $display("FAIL reset_scan edge=%0d sel=%b an=%b dp=%b want sel=%b an=%b dp=1", e, sel, an, dp, es, ~es);
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0] t_lz [4]   = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic [3:0] t_nolz [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] t_zero [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        for (int pass = 0; pass < 3; pass++) begin
            N        = (pass == 2) ? 16'h0000 : 16'h0042;
            blank_lz = (pass != 1);
            do_reset();
            for (int e = 1; e <= 16; e++) begin
                logic [3:0] ea;
                int idx;
                step();
                idx = (e / 4) % 4;
                ea  = (pass == 0) ? t_lz[idx] : (pass == 1) ? t_nolz[idx] : t_zero[idx];
                total++;
                if (an !== ea || sel !== ring[idx]) begin
                    bad++;
                    $display("FAIL blank pass=%0d edge=%0d an=%b sel=%b want an=%b sel=%b", pass, e, an, sel, ea, ring[idx]);
                end
            end
        end
    endtask

    task automatic test_hold();
        N = 16'h1234; blank_lz = 1'b0; dp_in = 4'b0000;
        do_reset();
        for (int e = 1; e <= 9; e++) step();
        hold = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            logic edp;
            step();
            edp = (c >= 6) ? 1'b0 : 1'b1;
            total++;
            if (sel !== 4'b0100 || an !== 4'b1011 || dp !== edp) begin
                bad++;
                $display("FAIL hold cyc=%0d sel=%b an=%b dp=%b want sel=0100 an=1011 dp=%b", c, sel, an, dp, edp);
            end
            if (c == 5) dp_in = 4'b0100;
        end
        hold = 1'b0; dp_in = 4'b0000;
        for (int e = 1; e <= 3; e++) begin
            logic [3:0] es;
            step();
            es = (e == 3) ? 4'b1000 : 4'b0100;
            total++;
            if (sel !== es || an !== ~es || dp !== 1'b1) begin
                bad++;
                $display("FAIL hold_release edge=%0d sel=%b an=%b dp=%b want sel=%b an=%b dp=1", e, sel, an, dp, es, ~es);
            end
        end
    endtask

    task automatic test_dp();
        dp_in = 4'b0100; N = 16'h1234; blank_lz = 1'b0;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            logic edp;
            step();
            edp = ((e / 4) % 4 == 2) ? 1'b0 : 1'b1;
            total++;
            if (dp !== edp) begin
                bad++;
                $display("FAIL dp_lit edge=%0d dp=%b want %b", e, dp, edp);
            end
        end
        dp_in = 4'b1000; N = 16'h0001; blank_lz = 1'b1;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            logic [3:0] ea;
            step();
            ea = ((e / 4) % 4 == 0) ? 4'b1110 : 4'b1111;
            total++;
            if (dp !== 1'b1 || an !== ea) begin
                bad++;
                $display("FAIL dp_blanked edge=%0d dp=%b an=%b want dp=1 an=%b", e, dp, an, ea);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        N = 16'h1234; blank_lz = 1'b0;
        do_reset();
        for (int e = 1; e <= 14; e++) step();
        total++;
        if (sel !== 4'b1000) begin
            bad++;
            $display("FAIL mid_pre sel=%b want 1000", sel);
        end
        reset = 1'b1; hold = 1'b1;
        step();
        reset = 1'b0; hold = 1'b0;
        total++;
        if (sel !== 4'b0001 || an !== 4'b1111 || dp !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset sel=%b an=%b dp=%b want sel=0001 an=1111 dp=1", sel, an, dp);
        end
        for (int e = 1; e <= 4; e++) begin
            logic [3:0] es;
            step();
            es = (e == 4) ? 4'b0010 : 4'b0001;
            total++;
            if (sel !== es || an !== ~es) begin
                bad++;
                $display("FAIL mid_resume edge=%0d sel=%b an=%b want sel=%b an=%b", e, sel, an, es, ~es);
            end
        end
    endtask

    task automatic test_div1();
        N = 16'h1234; blank_lz = 1'b0; hold = 1'b0; dp_in = 4'b0000;
        do_reset();
        total++;
        if (sel1 !== 4'b0001 || an1 !== 4'b1111 || dp1 !== 1'b1) begin
            bad++;
            $display("FAIL div1_reset sel=%b an=%b dp=%b want sel=0001 an=1111 dp=1", sel1, an1, dp1);
        end
        for (int e = 1; e <= 8; e++) begin
            logic [3:0] es;
            step();
            es = ring[e % 4];
            total++;
            if (sel1 !== es || an1 !== ~es || dp1 !== 1'b1) begin
                bad++;
                $display("FAIL div1_scan edge=%0d sel=%b an=%b dp=%b want sel=%b an=%b dp=1", e, sel1, an1, dp1, es, ~es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_hold();
        test_dp();
        test_reset_mid();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
Name: digit_scan_driver

Overview:
Time-multiplexing driver for the 4-digit seven-segment display, sitting directly upstream of the nibble selector. Generates the one-hot digit-select vector that picks a 4-bit nibble out of the 16-bit display word. Also generates the active-low anode and decimal-point drives, with optional leading-zero blanking. A built-in prescaler sets the per-digit dwell time.

Parameters:
DIV, 4, clock cycles per digit dwell; legal range 1..2^20; sizes the prescaler.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
hold  input  1  freezes the scan position while high
blank_lz  input  1  enables leading-zero blanking
N  input  16  display word; digit 3 = N[15:12], digit 0 = N[3:0]
dp_in  input  4  per-digit decimal point request, bit k = digit k
sel  output  4  one-hot digit select to the nibble selector; bit k selects digit k
an  output  4  anode drive, active-low, bit k = digit k
dp  output  1  decimal-point drive, active-low

Behaviour:
- Reset is sampled on the rising clk edge only. While reset=1 at an edge, the following values load on that edge:
  - sel=4'b0001
  - prescaler=0
  - an=4'b1111 (all off)
  - dp=1
- Reset wins over hold and over any tick. Asserting reset mid-scan returns to this state on the next edge, regardless of position.
- Prescaler:
  - Counts 0..DIV-1 while hold=0.
  - tick=1 in the cycle where the count equals DIV-1; the count wraps to 0 on that edge.
  - With DIV=1, tick=1 every cycle.
  - While hold=1, the count and sel are frozen and no tick is generated.
- Ring sequence:
  - On each edge where tick=1, sel rotates left: 0001->0010->0100->1000->0001.
  - If sel is ever not one-hot (zero or multiple bits set), the next tick loads 0001. This self-corrects the ring.
- Blank mask, computed combinationally from the current N and blank_lz:
  - digit 3 blanked iff blank_lz and N[15:12]==0
  - digit 2 blanked iff blank_lz and N[15:8]==0
  - digit 1 blanked iff blank_lz and N[15:4]==0
  - digit 0 is never blanked
- Anode and dp registers:
  - an and dp are registered and updated every non-reset edge, using the value sel takes on that same edge (sel_next).
  - an <= ~(sel_next & ~blank_mask).
  - dp <= ~|(sel_next & dp_in & ~blank_mask).
  - an and dp therefore always correspond to the current sel, with no extra cycle of lag.
  - Changes to N, blank_lz or dp_in appear on an/dp at the next edge (1-cycle latency), even while hold=1.
- At most one an bit is low at any time. an=1111 is legal only out of reset, or while the selected digit is blanked.
- sel is not gated by blanking; downstream decode is always fed.

Test Plan:
- Reset: DIV=4; hold reset 3 cycles, then release -> during reset an=1111, sel=0001, dp=1. First edge after release: an=1110. sel advances to 0010 exactly 4 edges after release, then to 0100 and 1000 at 4-cycle spacing, then wraps to 0001 (period 16).
- Blanking: N=16'h0042, blank_lz=1, full scan -> an sequence 1110, 1101, 1111, 1111. With blank_lz=0 -> 1110, 1101, 1011, 0111. With N=16'h0000 and blank_lz=1 -> only digit 0 lit (1110).
- Hold: assert hold while sel=0100 for 10 cycles -> sel stays 0100 and an stays 1011. After release, the first advance comes after the remaining prescaler count, not a full DIV.
- Decimal point: dp_in=4'b0100, blank_lz=0 -> dp=0 only while sel=0100, otherwise 1. dp_in=4'b1000 with N=16'h0001, blank_lz=1 -> dp stays 1, because digit 3 is blanked.
- Reset mid-scan: reset pulsed for 1 cycle while sel=1000 and prescaler=2 -> next edge gives sel=0001, an=1111. Scan then resumes from digit 0 with a full DIV dwell.
- DIV=1 build: sel rotates every cycle. an is one-hot-low and matches sel on every cycle after reset.
